// File: rtl/idct8_row_if.sv
// rtl/idct8_row_if.sv - coefficient-in / sample-out stream bundle for idct8_row
//
// Purpose: groups both handshake streams of the row IDCT.
// Signals:
//   in_data   signed coefficient X[k], natural order k=0..7
//   in_valid  in_data valid
//   in_ready  block accepts in_data this cycle
//   out_data  signed reconstructed sample x[n], order n=0..7
//   out_valid out_data valid
//   out_ready downstream accepts out_data
//   out_last  high with x[7] of each block
// Modports: slave = the IDCT block, master = the producer/consumer around it.

interface idct8_row_if #(
  parameter int IN_WIDTH  = 12,
  parameter int OUT_WIDTH = 9
) ();

  logic signed [IN_WIDTH-1:0]  in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_last;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_last
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_last
  );

endinterface

// File: rtl/idct8_row.sv
// rtl/idct8_row.sv - streaming 8-point 1-D inverse DCT, one coefficient in / one sample out per cycle
//
// Purpose: accepts X[0..7] serially, accumulates X[k]*C[n][k] into eight
// parallel accumulators, and on X[7] rounds/saturates the eight sums into an
// output bank that drains x[0..7] while the next block accumulates.
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset
//   bus  idct8_row_if.slave: in_data/in_valid/in_ready coefficient stream,
//        out_data/out_valid/out_ready/out_last sample stream

module idct8_row #(
  parameter int IN_WIDTH  = 12,
  parameter int OUT_WIDTH = 9
) (
  input logic         clk,
  input logic         rst,
  idct8_row_if.slave  bus
);

  // 14-bit Q12 coefficients; the product of a coefficient and an input is PW bits,
  // and eight such products summed cannot overflow AW bits.
  localparam int PW = IN_WIDTH + 14;
  localparam int AW = IN_WIDTH + 14 + 3;

  // MAG[0] is the DC magnitude 4096/(2*sqrt2); MAG[j], j=1..7, is 2048*cos(j*pi/16).
  localparam logic [13:0] MAG [0:7] = '{
    14'd1448, 14'd2009, 14'd1892, 14'd1703,
    14'd1448, 14'd1138, 14'd784,  14'd400
  };

  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [AW-1:0]        SAT_MAX = AW'(OUT_MAX);
  localparam logic signed [AW-1:0]        SAT_MIN = AW'(OUT_MIN);
  localparam logic signed [AW-1:0]        RND_HALF = AW'(2048);

  // C[n][k]: fold the cosine angle (2n+1)*k*pi/16 into the first quadrant.
  // For k>0 the folded index is always 1..7, so it never hits cos(0) or cos(pi/2).
  function automatic logic signed [13:0] coef(input int n, input logic [2:0] k);
    int   m;
    logic neg;
    logic signed [13:0] mag;
    neg = 1'b0;
    if (k == 3'd0) begin
      mag = $signed(MAG[0]);
    end else begin
      m = ((2 * n + 1) * int'(k)) % 32;
      if (m > 16) m = 32 - m;
      if (m > 8) begin
        neg = 1'b1;
        m   = 16 - m;
      end
      mag = $signed(MAG[m[2:0]]);
    end
    return neg ? -mag : mag;
  endfunction

  logic [2:0]                  k_cnt_q, k_cnt_d;
  logic [2:0]                  o_idx_q, o_idx_d;
  logic                        bank_full_q, bank_full_d;
  logic signed [AW-1:0]        acc_q [8];
  logic signed [AW-1:0]        acc_d [8];
  logic signed [OUT_WIDTH-1:0] bank_q [8];
  logic signed [OUT_WIDTH-1:0] bank_d [8];

  logic                        in_last;
  logic                        out_fire;
  logic                        drain_last;
  logic                        in_ready_c;
  logic                        in_fire;
  logic                        bank_wr;
  logic signed [PW-1:0]        prod [8];
  logic signed [AW-1:0]        sum  [8];
  logic signed [AW-1:0]        rnd  [8];

  always_comb begin
    in_last    = (k_cnt_q == 3'd7);
    out_fire   = bank_full_q && bus.out_ready;
    drain_last = out_fire && (o_idx_q == 3'd7);
    // X[7] may only land once the bank is free, or in the very cycle its last
    // sample leaves, which is what gives gap-free streaming.
    in_ready_c = !rst && (!in_last || !bank_full_q || drain_last);
    in_fire    = bus.in_valid && in_ready_c;
    bank_wr    = in_fire && in_last;

    k_cnt_d     = in_fire ? k_cnt_q + 3'd1 : k_cnt_q;
    o_idx_d     = o_idx_q;
    bank_full_d = bank_full_q;

    for (int n = 0; n < 8; n++) begin
      prod[n] = $signed(bus.in_data) * coef(n, k_cnt_q);
      // X[0] loads rather than adds, so a stale block never leaks into the next.
      sum[n]  = ((k_cnt_q == 3'd0) ? '0 : acc_q[n]) + AW'(prod[n]);
      acc_d[n] = in_fire ? sum[n] : acc_q[n];
      rnd[n]  = (sum[n] + RND_HALF) >>> 12;
      bank_d[n] = bank_q[n];
      if (bank_wr) begin
        if (rnd[n] > SAT_MAX)      bank_d[n] = OUT_MAX;
        else if (rnd[n] < SAT_MIN) bank_d[n] = OUT_MIN;
        else                       bank_d[n] = rnd[n][OUT_WIDTH-1:0];
      end
    end

    if (out_fire) begin
      if (o_idx_q == 3'd7) begin
        bank_full_d = 1'b0;
        o_idx_d     = 3'd0;
      end else begin
        o_idx_d = o_idx_q + 3'd1;
      end
    end
    // A refill wins over the drain-complete clear in the same cycle.
    if (bank_wr) begin
      bank_full_d = 1'b1;
      o_idx_d     = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_cnt_q     <= 3'd0;
      o_idx_q     <= 3'd0;
      bank_full_q <= 1'b0;
      for (int n = 0; n < 8; n++) begin
        acc_q[n]  <= '0;
        bank_q[n] <= '0;
      end
    end else begin
      k_cnt_q     <= k_cnt_d;
      o_idx_q     <= o_idx_d;
      bank_full_q <= bank_full_d;
      for (int n = 0; n < 8; n++) begin
        acc_q[n]  <= acc_d[n];
        bank_q[n] <= bank_d[n];
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = bank_full_q;
  assign bus.out_data  = bank_q[o_idx_q];
  assign bus.out_last  = bank_full_q && (o_idx_q == 3'd7);

endmodule

// File: tb/tb_idct8_row.sv
// tb/tb_idct8_row.sv - self-checking bench for idct8_row

module tb_idct8_row;

  localparam int  IW = 12;
  localparam int  OW = 9;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  idct8_row_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  idct8_row #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int exp_q [$];
  int beat       = 0;
  bit win_en     = 1'b0;
  int win_cycles = 0;
  int win_valid  = 0;
  int stall_cnt  = 0;
  int mon_exp;
  logic mon_last;

  // Reference coefficient straight from the cosine definition.
  function automatic int coef_ref(input int n, input int k);
    real c;
    real v;
    c = (k == 0) ? 1.0 / (2.0 * $sqrt(2.0)) : 0.5;
    v = 4096.0 * c * $cos(real'((2 * n + 1) * k) * PI / 16.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic int model(input int x [8], input int n);
    longint s;
    s = 0;
    for (int k = 0; k < 8; k++) s += longint'(x[k]) * longint'(coef_ref(n, k));
    s = (s + 2048) >>> 12;
    if (s > (2 ** (OW - 1)) - 1) s = (2 ** (OW - 1)) - 1;
    if (s < -(2 ** (OW - 1)))    s = -(2 ** (OW - 1));
    return int'(s);
  endfunction

  task automatic push_model(input int x [8]);
    for (int n = 0; n < 8; n++) exp_q.push_back(model(x, n));
  endtask

  task automatic push_list(input int y [8]);
    for (int n = 0; n < 8; n++) exp_q.push_back(y[n]);
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one coefficient and hold it until accepted; returns just after the accept edge.
  task automatic send(input int x);
    bit done;
    done = 1'b0;
    bus.in_data  = IW'(x);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      else stall_cnt++;
      tick();
    end
    chk("send_accepted", 32'(done), 32'sd1);
  endtask

  task automatic send_block(input int x [8]);
    for (int k = 0; k < 8; k++) send(x[k]);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick();
    chk("drain_complete", exp_q.size(), 0);
  endtask

  // Scoreboard side: every output transfer is popped and compared.
  always @(negedge clk) begin
    if (win_en) begin
      win_cycles++;
      if (bus.out_valid) win_valid++;
    end
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      assert (exp_q.size() > 0)
      else begin
        failures++;
        $error("FAIL unexpected_output observed=%0d expected=none", $signed(bus.out_data));
      end
      if (exp_q.size() > 0) begin
        mon_exp  = exp_q.pop_front();
        mon_last = (beat % 8 == 7);
        checks++;
        assert (int'($signed(bus.out_data)) === mon_exp)
        else begin
          failures++;
          $error("FAIL out_data beat=%0d observed=%0d expected=%0d", beat, $signed(bus.out_data), mon_exp);
        end
        checks++;
        assert (bus.out_last === mon_last)
        else begin
          failures++;
          $error("FAIL out_last beat=%0d observed=%0b expected=%0b", beat, bus.out_last, mon_last);
        end
        beat++;
      end
    end
  end

  int dc64  [8];
  int dcm64 [8];
  int ac100 [8];
  int ac_y  [8];
  int sat_p [8];
  int sat_n [8];
  int c23   [8];
  int cm23  [8];
  int c255  [8];
  int cm256 [8];
  int rnd_a [8];
  int rnd_b [8];

  initial begin
    dc64  = '{64, 0, 0, 0, 0, 0, 0, 0};
    dcm64 = '{-64, 0, 0, 0, 0, 0, 0, 0};
    ac100 = '{0, 100, 0, 0, 0, 0, 0, 0};
    ac_y  = '{49, 42, 28, 10, -10, -28, -42, -49};
    sat_p = '{2047, 0, 0, 0, 0, 0, 0, 0};
    sat_n = '{-2048, 0, 0, 0, 0, 0, 0, 0};
    c23   = '{23, 23, 23, 23, 23, 23, 23, 23};
    cm23  = '{-23, -23, -23, -23, -23, -23, -23, -23};
    c255  = '{255, 255, 255, 255, 255, 255, 255, 255};
    cm256 = '{-256, -256, -256, -256, -256, -256, -256, -256};
    for (int k = 0; k < 8; k++) begin
      rnd_a[k] = int'($urandom_range(4095)) - 2048;
      rnd_b[k] = int'($urandom_range(511)) - 256;
    end

    // Reset state
    rst           = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("in_ready_in_reset", 32'(bus.in_ready), 32'sd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(bus.out_valid), 32'sd0);
    chk("reset_out_last", 32'(bus.out_last), 32'sd0);
    chk("reset_out_data", $signed(bus.out_data), 32'sd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'sd1);
    tick();

    // DC block with latency check
    bus.out_ready = 1'b1;
    push_list(c23);
    for (int k = 0; k < 7; k++) send(dc64[k]);
    chk("dc_no_early_valid", 32'(bus.out_valid), 32'sd0);
    send(dc64[7]);
    bus.in_valid = 1'b0;
    chk("dc_latency_valid", 32'(bus.out_valid), 32'sd1);
    wait_drain();

    // Single AC and both saturation limits
    push_list(ac_y);
    send_block(ac100);
    push_list(c255);
    send_block(sat_p);
    push_list(cm256);
    send_block(sat_n);
    bus.in_valid = 1'b0;
    wait_drain();

    // Random full block against the reference model
    push_model(rnd_a);
    send_block(rnd_a);
    bus.in_valid = 1'b0;
    wait_drain();

    // Back-to-back streaming of three blocks
    push_list(c23);
    push_list(ac_y);
    push_list(cm23);
    stall_cnt = 0;
    send_block(dc64);
    win_cycles = 0;
    win_valid  = 0;
    win_en     = 1'b1;
    send_block(ac100);
    send_block(dcm64);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 100 && win_cycles < 24; i++) tick();
    win_en = 1'b0;
    chk("stream_valid_cycles", win_valid, 32'sd24);
    chk("stream_in_stalls", stall_cnt, 32'sd0);
    wait_drain();

    // Backpressure: block A held, block B waits at X[7]
    bus.out_ready = 1'b0;
    push_list(ac_y);
    push_model(rnd_b);
    stall_cnt = 0;
    send_block(ac100);
    for (int k = 0; k < 7; k++) send(rnd_b[k]);
    chk("bp_first7_no_stall", stall_cnt, 32'sd0);
    bus.in_data  = IW'(rnd_b[7]);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 32'(bus.in_ready), 32'sd0);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'sd1);
      chk("bp_hold_data", $signed(bus.out_data), 32'sd49);
      chk("bp_hold_last", 32'(bus.out_last), 32'sd0);
      tick();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("bp_refill_ready", 32'(bus.in_ready), (i == 7) ? 32'sd1 : 32'sd0);
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_b_follows", 32'(bus.out_valid), 32'sd1);
    tick();
    wait_drain();

    // Reset mid-block discards the partial accumulation
    for (int k = 0; k < 4; k++) send(dc64[k]);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_in_ready", 32'(bus.in_ready), 32'sd0);
    tick();
    rst = 1'b0;
    push_list(ac_y);
    send_block(ac100);
    bus.in_valid = 1'b0;
    wait_drain();

    repeat (3) tick();
    chk("queue_empty_at_end", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
